// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : score_keeper                                               |
// | Description : Accumulates per-player capture totals, requests territory  |
// |               counts from the territory counter, and produces final      |
// |               half-point scores with komi plus a winner indication.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module score_keeper #(
   parameter int KOMI_X2        = 13,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       new_game,
   input  logic       capture_pulse,
   input  logic [1:0] capture_color,
   input  logic [6:0] capture_count,
   input  logic       score_req,
   output logic       terr_update_pulse,
   input  logic [7:0] bterr_in,
   input  logic [7:0] wterr_in,
   input  logic       terr_ready,
   output logic [7:0] bcaps_out,
   output logic [7:0] wcaps_out,
   output logic [9:0] bscore_x2,
   output logic [9:0] wscore_x2,
   output logic [1:0] winner,
   output logic       score_valid,
   output logic       stale_out,
   output logic       busy_out
);

   // Timer only has to reach TIMEOUT_CYCLES-1.
   localparam int              TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   C_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [9:0]      C_KOMI       = 10'(KOMI_X2);
   localparam logic [1:0]      C_WIN_TIE    = 2'b00;
   localparam logic [1:0]      C_WIN_BLACK  = 2'b01;
   localparam logic [1:0]      C_WIN_WHITE  = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_WAIT = 4'b0010,
      ST_SUM  = 4'b0100,
      ST_CMP  = 4'b1000
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    bcaps_q, bcaps_d;
   logic [7:0]    wcaps_q, wcaps_d;
   logic [7:0]    bterr_q, bterr_d;
   logic [7:0]    wterr_q, wterr_d;
   logic [9:0]    bscore_q, bscore_d;
   logic [9:0]    wscore_q, wscore_d;
   logic [1:0]    winner_q, winner_d;
   logic          stale_flag_q, stale_flag_d;
   logic          stale_q, stale_d;
   logic          valid_q, valid_d;
   logic          pulse_q, pulse_d;
   logic          busy_q, busy_d;

   logic [8:0]    bsum;
   logic [8:0]    wsum;

   // Capture totals clamp at 255 instead of wrapping.
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [6:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {2'b00, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   assign bsum = {1'b0, bterr_q} + {1'b0, bcaps_q};
   assign wsum = {1'b0, wterr_q} + {1'b0, wcaps_q};

   // Next-state logic: capture accounting, scoring sequence, new_game override.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      bcaps_d      = bcaps_q;
      wcaps_d      = wcaps_q;
      bterr_d      = bterr_q;
      wterr_d      = wterr_q;
      bscore_d     = bscore_q;
      wscore_d     = wscore_q;
      winner_d     = winner_q;
      stale_flag_d = stale_flag_q;
      stale_d      = stale_q;
      valid_d      = 1'b0;
      pulse_d      = 1'b0;

      if (capture_pulse) begin
         if (capture_color == 2'b01) bcaps_d = sat_add(bcaps_q, capture_count);
         if (capture_color == 2'b10) wcaps_d = sat_add(wcaps_q, capture_count);
      end

      case (state_q)
         ST_IDLE: begin
            if (score_req) begin
               pulse_d = 1'b1;
               timer_d = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A ready pulse on the timeout cycle still counts as fresh data.
            if (terr_ready) begin
               bterr_d      = bterr_in;
               wterr_d      = wterr_in;
               stale_flag_d = 1'b0;
               state_d      = ST_SUM;
            end else if (timer_q == C_TIMER_LAST) begin
               stale_flag_d = 1'b1;
               state_d      = ST_SUM;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_SUM: begin
            // Uses capture totals as registered now; a capture this cycle lands afterwards.
            bscore_d = {bsum, 1'b0};
            wscore_d = {wsum, 1'b0} + C_KOMI;
            state_d  = ST_CMP;
         end
         ST_CMP: begin
            if (bscore_q > wscore_q)      winner_d = C_WIN_BLACK;
            else if (wscore_q > bscore_q) winner_d = C_WIN_WHITE;
            else                          winner_d = C_WIN_TIE;
            stale_d = stale_flag_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (new_game) begin
         state_d      = ST_IDLE;
         timer_d      = '0;
         bcaps_d      = '0;
         wcaps_d      = '0;
         bterr_d      = '0;
         wterr_d      = '0;
         bscore_d     = '0;
         wscore_d     = '0;
         winner_d     = C_WIN_TIE;
         stale_flag_d = 1'b0;
         stale_d      = 1'b0;
         valid_d      = 1'b0;
         pulse_d      = 1'b0;
      end

      // Busy stays high through the cycle that presents score_valid.
      busy_d = (state_d != ST_IDLE) || valid_d;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         bcaps_q      <= '0;
         wcaps_q      <= '0;
         bterr_q      <= '0;
         wterr_q      <= '0;
         bscore_q     <= '0;
         wscore_q     <= '0;
         winner_q     <= C_WIN_TIE;
         stale_flag_q <= 1'b0;
         stale_q      <= 1'b0;
         valid_q      <= 1'b0;
         pulse_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         bcaps_q      <= bcaps_d;
         wcaps_q      <= wcaps_d;
         bterr_q      <= bterr_d;
         wterr_q      <= wterr_d;
         bscore_q     <= bscore_d;
         wscore_q     <= wscore_d;
         winner_q     <= winner_d;
         stale_flag_q <= stale_flag_d;
         stale_q      <= stale_d;
         valid_q      <= valid_d;
         pulse_q      <= pulse_d;
         busy_q       <= busy_d;
      end
   end

   assign terr_update_pulse = pulse_q;
   assign bcaps_out         = bcaps_q;
   assign wcaps_out         = wcaps_q;
   assign bscore_x2         = bscore_q;
   assign wscore_x2         = wscore_q;
   assign winner            = winner_q;
   assign score_valid       = valid_q;
   assign stale_out         = stale_q;
   assign busy_out          = busy_q;

endmodule
`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-scoring stage directly downstream of the territory counter.
- Accumulates per-player capture totals from move-commit events.
- On a score request, pulses the territory counter's update input and waits for its ready pulse. It then latches the territory counts.
- Computes final half-point scores with komi, reports the winner, and pulses a valid strobe.

Parameters:
- KOMI_X2, 13, komi in half-points (13 = 6.5), added to White; range 0..255
- TIMEOUT_CYCLES, 1023, maximum wait for terr_ready before falling back to last latched territory

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- new_game  input  1  one-cycle pulse; clears captures, latched territory, scores
- capture_pulse  input  1  one-cycle pulse; a move removed stones
- capture_color  input  2  capturing player: 2'b01 black, 2'b10 white; 00/11 ignored
- capture_count  input  7  stones removed by that move (0..80)
- score_req  input  1  one-cycle pulse requesting a score
- terr_update_pulse  output  1  one-cycle pulse to territory counter update input
- bterr_in  input  8  black territory count from territory counter
- wterr_in  input  8  white territory count from territory counter
- terr_ready  input  1  one-cycle pulse; bterr_in/wterr_in valid this cycle
- bcaps_out  output  8  black capture total
- wcaps_out  output  8  white capture total
- bscore_x2  output  10  black score in half-points
- wscore_x2  output  10  white score in half-points
- winner  output  2  01 black, 10 white, 00 tie
- score_valid  output  1  one-cycle pulse; scores and winner updated
- stale_out  output  1  last result used fallback territory (timeout)
- busy_out  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_in=0, async): all outputs 0, latched territory 0, timer 0, state IDLE.
- All outputs are registered.

Capture accounting (any state):
- On capture_pulse, add capture_count to the capturing colour's total.
- Totals saturate at 255; they never wrap.
- new_game in the same cycle as capture_pulse: new_game wins, totals become 0.
- new_game clears totals, latched territory, bscore_x2, wscore_x2, winner, stale_out.
- new_game forces state IDLE and terr_update_pulse to 0. A scoring sequence in progress is aborted and no score_valid is issued.

FSM (one-hot):
- IDLE:
  - score_req=1 → terr_update_pulse<=1, timer<=0, state WAIT_TERR.
  - score_req is ignored in every other state.
- WAIT_TERR:
  - terr_update_pulse<=0 on the first cycle here, so it is exactly one cycle wide.
  - terr_ready=1 → latch bterr_in/wterr_in, stale flag<=0, state SUM.
  - Else, timer==TIMEOUT_CYCLES-1 → keep previous latched territory, stale flag<=1, state SUM.
  - Else timer+1.
  - A terr_ready in the same cycle the timeout is reached counts as ready, not timeout.
- SUM:
  - Snapshot capture totals as they stand at this edge.
  - bscore_x2 <= 2*(bterr + bcaps).
  - wscore_x2 <= 2*(wterr + wcaps) + KOMI_X2.
  - Computed in 10 bits; maximum 2*(81+255)+255 = 927, so no overflow.
  - State CMP.
- CMP:
  - winner <= 01 if b>w, 10 if w>b, 00 if equal.
  - stale_out <= stale flag, score_valid<=1, state IDLE.
- score_valid drops the following cycle.
- terr_ready pulses arriving in IDLE, SUM or CMP are ignored.
- Latency from score_req edge to score_valid high: 4 cycles plus the territory counter's response time.
- busy_out=1 from the cycle after score_req through the score_valid cycle.

Test Plan:
- Reset and idle: hold rst_in low mid-sequence → all outputs 0 immediately (async); release with no stimulus → stays idle, busy_out=0.
- Captures: black captures 3 then 5, white captures 2 → bcaps_out=8, wcaps_out=2. Then black 80 ×4 → bcaps_out saturates at 255.
- Full score: caps b=8, w=2, score_req, terr_update_pulse observed for one cycle, model terr_ready 6 cycles later with bterr_in=20, wterr_in=25 → bscore_x2=56, wscore_x2=67, winner=10, score_valid single pulse, stale_out=0.
- Tie with KOMI_X2=0: b terr 10, caps 0; w terr 10, caps 0 → both scores 20, winner=00.
- Timeout: no terr_ready after a prior successful score with territory 20/25 → score_valid after TIMEOUT_CYCLES using 20/25, stale_out=1.
- Abort and collision: new_game during WAIT_TERR with simultaneous capture_pulse → state IDLE, totals 0, no score_valid. A later terr_ready is ignored. A score_req issued while busy is ignored.
